// File: rtl/shift_register_pkg.sv
// Shared definitions for the parametrised shift register / delay line.
// Mode encodings are common to the top level and every stage.
package shift_register_pkg;

  localparam logic [1:0] SR_MODE_FWD   = 2'b00;
  localparam logic [1:0] SR_MODE_REV   = 2'b01;
  localparam logic [1:0] SR_MODE_ROT   = 2'b10;
  localparam logic [1:0] SR_MODE_FLUSH = 2'b11;

  // Only true shifts advance the fill tracker; rotation just recirculates.
  function automatic logic sr_counts_shift(input logic [1:0] mode);
    return (mode == SR_MODE_FWD) || (mode == SR_MODE_REV);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit storage stage with its own next-value selection, so the
// top level only has to wire neighbours together.
module shift_stage
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fwd_in,
  input  logic [WIDTH-1:0] rev_in,
  input  logic [WIDTH-1:0] rot_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] next_q;

  always_comb begin
    next_q = '0;
    case (mode)
      SR_MODE_FWD:   next_q = fwd_in;
      SR_MODE_REV:   next_q = rev_in;
      SR_MODE_ROT:   next_q = rot_in;
      SR_MODE_FLUSH: next_q = '0;
      default:       next_q = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= next_q;
    end
  end

endmodule

// File: rtl/shift_register_param.sv
// WIDTH x DEPTH shift register / programmable delay line with enable,
// forward/reverse shift, rotation, flush, run-time tap and fill tracking.
module shift_register_param
  import shift_register_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 124,
  localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rev_out,
  output logic [WIDTH-1:0] tap_out,
  output logic [CNT_W-1:0] fill_count,
  output logic             primed
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Stage 0 takes the serial input going forward and the far end when
  // rotating; the last stage takes the serial input going in reverse.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_src;
    logic [WIDTH-1:0] rev_src;
    logic [WIDTH-1:0] rot_src;

    if (i == 0) begin : g_head
      assign fwd_src = data_in;
      assign rot_src = stage_q[DEPTH-1];
    end else begin : g_body
      assign fwd_src = stage_q[i-1];
      assign rot_src = stage_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign rev_src = data_in;
    end else begin : g_inner
      assign rev_src = stage_q[i+1];
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .fwd_in (fwd_src),
      .rev_in (rev_src),
      .rot_in (rot_src),
      .q      (stage_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_count <= '0;
    end else if (en) begin
      if (mode == SR_MODE_FLUSH) begin
        fill_count <= '0;
      end else if (sr_counts_shift(mode) && (fill_count != FILL_MAX)) begin
        fill_count <= fill_count + 1'b1;
      end
    end
  end

  // Out-of-range selects fall through to zero rather than aliasing a stage.
  always_comb begin
    tap_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(tap_sel) == i) begin
        tap_out = stage_q[i];
      end
    end
  end

  assign data_out = stage_q[DEPTH-1];
  assign rev_out  = stage_q[0];
  assign primed   = (fill_count == FILL_MAX);

endmodule

// File: tb/tb_shift_register_param.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor
// pops and compares them against the three shift register instances.
module tb_shift_register_param;
  import shift_register_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] data_in;
  logic [1:0] tap_sel;
  logic [7:0] data_out, rev_out, tap_out;
  logic [2:0] fill_count;
  logic       primed;

  logic [2:0] tap5;
  logic [7:0] d5_data, d5_rev, d5_tap;
  logic [2:0] d5_fill;
  logic       d5_primed;

  logic       en_b;
  logic [1:0] mode_b;
  logic       din_b;
  logic [6:0] tap_b;
  logic       b_data, b_rev, b_tap;
  logic [6:0] b_fill;
  logic       b_primed;

  shift_register_param #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data_in(data_in),
    .tap_sel(tap_sel), .data_out(data_out), .rev_out(rev_out),
    .tap_out(tap_out), .fill_count(fill_count), .primed(primed)
  );

  shift_register_param #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data_in(data_in),
    .tap_sel(tap5), .data_out(d5_data), .rev_out(d5_rev),
    .tap_out(d5_tap), .fill_count(d5_fill), .primed(d5_primed)
  );

  shift_register_param dut_def (
    .clk(clk), .reset(reset), .en(en_b), .mode(mode_b), .data_in(din_b),
    .tap_sel(tap_b), .data_out(b_data), .rev_out(b_rev),
    .tap_out(b_tap), .fill_count(b_fill), .primed(b_primed)
  );

  typedef struct packed {
    logic [127:0] name;
    logic [3:0]   sel;
    logic [31:0]  exp;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input logic [3:0] sel);
    case (sel)
      4'd0:    return 32'(data_out);
      4'd1:    return 32'(rev_out);
      4'd2:    return 32'(tap_out);
      4'd3:    return 32'(fill_count);
      4'd4:    return 32'(primed);
      4'd5:    return 32'(d5_tap);
      4'd6:    return 32'(b_data);
      4'd7:    return 32'(b_primed);
      4'd8:    return 32'(b_fill);
      4'd9:    return 32'(b_rev);
      4'd10:   return 32'(d5_data);
      4'd11:   return 32'(d5_rev);
      4'd12:   return 32'(d5_fill);
      4'd13:   return 32'(d5_primed);
      4'd14:   return 32'(b_tap);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c     = sb.pop_front();
      act   = actual(c.sel);
      total = total + 1;
      if (act !== c.exp) begin
        bad = bad + 1;
        $display("[TB] FAIL %0s: actual=%0h required=%0h", c.name, act, c.exp);
      end
    end
    total = total + 3;
    if (primed !== (fill_count == 3'd4)) begin
      bad = bad + 1;
      $display("[TB] FAIL primed invariant: actual=%0h required=%0h", primed, (fill_count == 3'd4));
    end
    if (d5_primed !== (d5_fill == 3'd5)) begin
      bad = bad + 1;
      $display("[TB] FAIL d5 primed invariant: actual=%0h required=%0h", d5_primed, (d5_fill == 3'd5));
    end
    if (b_primed !== (b_fill == 7'd124)) begin
      bad = bad + 1;
      $display("[TB] FAIL def primed invariant: actual=%0h required=%0h", b_primed, (b_fill == 7'd124));
    end
  end

  task automatic checkOutput(input logic [127:0] name, input logic [3:0] sel,
                             input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  // One enabled edge on the WIDTH=8 instances; en drops again right after it.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    #1;
    en      = e;
    mode    = m;
    data_in = d;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic setTap(input logic [1:0] t, input logic [2:0] t5);
    @(negedge clk);
    #1;
    tap_sel = t;
    tap5    = t5;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic hist[$];
    logic exp_data;
    int   k;

    reset = 1'b1; en = 1'b1; mode = SR_MODE_FWD; data_in = 8'h11;
    tap_sel = 2'd0; tap5 = 3'd0;
    en_b = 1'b0; mode_b = SR_MODE_FWD; din_b = 1'b0; tap_b = 7'd0;

    // Outputs stay cleared while reset is held, even with shifts requested.
    @(posedge clk); #1;
    checkOutput("rst data_out", 4'd0, 32'h0);
    checkOutput("rst rev_out", 4'd1, 32'h0);
    checkOutput("rst tap_out", 4'd2, 32'h0);
    checkOutput("rst fill", 4'd3, 32'h0);
    checkOutput("rst primed", 4'd4, 32'h0);
    @(negedge clk); #1;
    en = 1'b0;
    reset = 1'b0;

    applyStimulus(1'b1, SR_MODE_FWD, 8'h11);
    checkOutput("fwd1 rev_out", 4'd1, 32'h11);
    checkOutput("fwd1 fill", 4'd3, 32'd1);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h22);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h33);
    checkOutput("fwd3 data_out", 4'd0, 32'h0);
    checkOutput("fwd3 primed", 4'd4, 32'h0);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h44);
    checkOutput("fwd4 data_out", 4'd0, 32'h11);
    checkOutput("fwd4 primed", 4'd4, 32'h1);
    checkOutput("fwd4 fill", 4'd3, 32'd4);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h55);
    checkOutput("fwd5 data_out", 4'd0, 32'h22);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, SR_MODE_FWD, 8'hA0 + 8'(i));
    setTap(2'd0, 3'd5);
    checkOutput("tap0", 4'd2, 32'hA3);
    checkOutput("d5 tap5", 4'd5, 32'h0);
    setTap(2'd1, 3'd7);
    checkOutput("tap1", 4'd2, 32'hA2);
    checkOutput("d5 tap7", 4'd5, 32'h0);
    setTap(2'd2, 3'd4);
    checkOutput("tap2", 4'd2, 32'hA1);
    checkOutput("d5 tap4", 4'd5, 32'h55);
    setTap(2'd3, 3'd0);
    checkOutput("tap3", 4'd2, 32'hA0);
    checkOutput("d5 tap0", 4'd5, 32'hA3);

    applyStimulus(1'b1, SR_MODE_REV, 8'hFF);
    checkOutput("rev rev_out", 4'd1, 32'hA2);
    checkOutput("rev data_out", 4'd0, 32'hFF);
    checkOutput("rev fill", 4'd3, 32'd4);
    checkOutput("d5 rev data", 4'd10, 32'hFF);
    checkOutput("d5 rev rev_out", 4'd11, 32'hA2);
    checkOutput("d5 fill", 4'd12, 32'd5);
    checkOutput("d5 primed", 4'd13, 32'h1);

    // Rotation with idle (en low) edges interleaved, one of them a FLUSH.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, SR_MODE_FWD, 8'hA0 + 8'(i));
    setTap(2'd2, 3'd0);
    applyStimulus(1'b1, SR_MODE_ROT, 8'h77);
    checkOutput("rot1 data_out", 4'd0, 32'hA1);
    checkOutput("rot1 rev_out", 4'd1, 32'hA0);
    applyStimulus(1'b0, SR_MODE_ROT, 8'h00);
    checkOutput("idle rot data_out", 4'd0, 32'hA1);
    applyStimulus(1'b1, SR_MODE_ROT, 8'h00);
    checkOutput("rot2 data_out", 4'd0, 32'hA2);
    applyStimulus(1'b0, SR_MODE_FLUSH, 8'h00);
    checkOutput("idle flush data_out", 4'd0, 32'hA2);
    checkOutput("idle flush fill", 4'd3, 32'd4);
    applyStimulus(1'b1, SR_MODE_ROT, 8'h00);
    checkOutput("rot3 data_out", 4'd0, 32'hA3);
    applyStimulus(1'b1, SR_MODE_ROT, 8'h00);
    checkOutput("rot4 data_out", 4'd0, 32'hA0);
    checkOutput("rot4 rev_out", 4'd1, 32'hA3);
    checkOutput("rot4 tap2", 4'd2, 32'hA1);
    checkOutput("rot4 fill", 4'd3, 32'd4);

    // Saturation from an empty line, then flush.
    applyStimulus(1'b1, SR_MODE_FLUSH, 8'h00);
    checkOutput("flush0 fill", 4'd3, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, SR_MODE_FWD, 8'(i));
      if (i == 3) checkOutput("sat3 fill", 4'd3, 32'd3);
    end
    checkOutput("sat10 fill", 4'd3, 32'd4);
    checkOutput("sat10 data_out", 4'd0, 32'h07);
    checkOutput("sat10 primed", 4'd4, 32'h1);
    applyStimulus(1'b1, SR_MODE_FLUSH, 8'h5A);
    checkOutput("flush data_out", 4'd0, 32'h0);
    checkOutput("flush rev_out", 4'd1, 32'h0);
    checkOutput("flush tap2", 4'd2, 32'h0);
    checkOutput("flush fill", 4'd3, 32'd0);
    checkOutput("flush primed", 4'd4, 32'h0);

    applyStimulus(1'b1, SR_MODE_FWD, 8'h3C);
    checkOutput("post flush fill", 4'd3, 32'd1);
    setTap(2'd1, 3'd0);
    applyStimulus(1'b1, SR_MODE_ROT, 8'hEE);
    checkOutput("rot partial fill", 4'd3, 32'd1);
    checkOutput("rot partial rev_out", 4'd1, 32'h0);
    checkOutput("rot partial tap1", 4'd2, 32'h3C);
    applyStimulus(1'b1, SR_MODE_REV, 8'h77);
    checkOutput("mixed fill", 4'd3, 32'd2);
    checkOutput("mixed rev_out", 4'd1, 32'h3C);
    checkOutput("mixed data_out", 4'd0, 32'h77);

    // Reset raised between edges must clear state before the next edge.
    applyStimulus(1'b1, SR_MODE_FWD, 8'h99);
    #1;
    reset = 1'b1;
    checkOutput("async rev_out", 4'd1, 32'h0);
    checkOutput("async data_out", 4'd0, 32'h0);
    checkOutput("async fill", 4'd3, 32'd0);
    checkOutput("d5 async rev_out", 4'd11, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b1, SR_MODE_FWD, 8'h5A);
    checkOutput("after rst fill", 4'd3, 32'd1);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h00);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h00);
    checkOutput("after rst edge3", 4'd0, 32'h0);
    applyStimulus(1'b1, SR_MODE_FWD, 8'h00);
    checkOutput("after rst edge4", 4'd0, 32'h5A);
    checkOutput("after rst primed", 4'd4, 32'h1);

    // Default 1x124 instance as a delay line with sporadic enable gaps.
    k = 0;
    for (int n = 0; n < 420; n++) begin
      @(negedge clk); #1;
      en_b  = ($urandom_range(0, 7) != 0);
      din_b = 1'($urandom_range(0, 1));
      mode_b = SR_MODE_FWD;
      @(posedge clk); #1;
      if (en_b) begin
        hist.push_back(din_b);
        k = k + 1;
      end
      en_b = 1'b0;
      exp_data = (k >= 124) ? hist[k-124] : 1'b0;
      checkOutput("def data_out", 4'd6, 32'(exp_data));
      checkOutput("def primed", 4'd7, 32'(k >= 124));
      checkOutput("def fill", 4'd8, (k >= 124) ? 32'd124 : 32'(k));
      if (k > 0) begin
        checkOutput("def rev_out", 4'd9, 32'(hist[k-1]));
        checkOutput("def tap0", 4'd14, 32'(hist[k-1]));
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_param.md
# shift_register_param

Parametrised multi-bit shift register and delay line, the successor to the fixed 124-stage single-bit chain. It is `WIDTH` bits wide and `DEPTH` stages deep. It adds a clock enable, forward/reverse shifting, rotation, synchronous flush, a run-time selectable tap and a fill tracker. It sits in serial datapaths as a programmable delay or a deserialiser staging buffer.

## Interface
- `WIDTH`, default 1: bits per stage; must be ≥1.
- `DEPTH`, default 124: number of stages; must be ≥1.
- `TAP_W` (derived localparam): `max(1, $clog2(DEPTH))`.
- `CNT_W` (derived localparam): `$clog2(DEPTH+1)`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: operation enable; when low, all state holds.
- `mode` in 2: operation, see Operation.
- `data_in` in `WIDTH`: serial input word.
- `tap_sel` in `TAP_W`: stage index for `tap_out`.
- `data_out` out `WIDTH`: stage[DEPTH-1].
- `rev_out` out `WIDTH`: stage[0].
- `tap_out` out `WIDTH`: stage[tap_sel], combinational.
- `fill_count` out `CNT_W`: shifts since last reset/flush, saturating at `DEPTH`.
- `primed` out 1: high when `fill_count == DEPTH`.

## Operation
State is stage[0..DEPTH-1] (each `WIDTH` bits) plus `fill_count`. The `mode` encodings apply only on edges where `en`=1:
- 2'b00 SHIFT_FWD: stage[0] ← `data_in`; stage[i] ← stage[i-1]; `fill_count` += 1, saturating at `DEPTH`.
- 2'b01 SHIFT_REV: stage[DEPTH-1] ← `data_in`; stage[i] ← stage[i+1]; `fill_count` += 1, saturating.
- 2'b10 ROTATE_FWD: stage[0] ← stage[DEPTH-1]; stage[i] ← stage[i-1]; `data_in` is ignored; `fill_count` is unchanged.
- 2'b11 FLUSH: all stages ← 0; `fill_count` ← 0.

Behaviour with `en` low and at boundaries:
- `en`=0: every register holds, whatever `mode` is. FLUSH also requires `en`=1.
- `fill_count` counts shift operations, not direction-specific occupancy. Mixing FWD and REV shifts still increments it.
- `tap_sel` ≥ `DEPTH`: `tap_out` = 0.
- `DEPTH`=1: FWD and REV are identical (stage[0] ← `data_in`), and ROTATE holds.
- Reset values: all stages 0, `fill_count` 0, `primed` 0, so `data_out`, `rev_out` and `tap_out` are all 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. The first enabled edge after deassertion behaves like the first after power-up.

## Timing
- Every register updates on the rising edge of `clk` when `en`=1.
- Latency in SHIFT_FWD: a word presented with `data_in` at enabled edge k appears on `data_out` after enabled edge k+DEPTH-1. That is DEPTH enabled edges inclusive, which makes this a DEPTH-cycle delay line when `en` is held high.
- Cycles with `en`=0 add no latency credit: the delay is counted in enabled edges, not clock cycles.
- `tap_out` is combinational from `tap_sel` and the stage registers, with no added latency. Word k is visible on `tap_out` with `tap_sel`=j after enabled edge k+j.
- `primed` is registered-equivalent: it is derived from `fill_count` and rises after the DEPTH-th counted shift.
- A mode change takes effect on the next enabled edge. There is no pipeline and no hazard between consecutive modes.

## Structure
- Shared package `shift_register_pkg` holds the mode constants `SR_MODE_FWD`, `SR_MODE_REV`, `SR_MODE_ROT`, `SR_MODE_FLUSH` (2-bit).
- Sub-module `shift_stage`: one `WIDTH`-bit register with async active-high `reset` and enable. Its inputs are `fwd_in`, `rev_in`, `rot_in` and `mode`, and it contains the next-value mux.
- The top level generates `DEPTH` instances of `shift_stage`. It wires stage 0's `fwd_in` to `data_in` and its `rot_in` to stage[DEPTH-1], and stage[DEPTH-1]'s `rev_in` to `data_in`. It also holds the fill counter and the tap mux.

## Test plan
All scenarios use `WIDTH`=8, `DEPTH`=4 unless noted.
- Reset / delay line: assert `reset`, then shift FWD 8'h11, 22, 33, 44, 55 with `en`=1 → all outputs 0 during reset. `data_out`=8'h11 after the 4th edge and 8'h22 after the 5th. `primed` rises after the 4th edge.
- Tap and REV: after FWD 8'hA0..A3, set `tap_sel`=0..3 → `tap_out` = A3, A2, A1, A0. Then `tap_sel`=5 → `tap_out` = 0. Then REV-shift 8'hFF → `rev_out` = A2 and `data_out` = FF.
- Rotate and enable: with stages {A3, A2, A1, A0}, ROTATE ×4 → contents return to the start and `fill_count` is unchanged. Interleave `en`=0 cycles → no change on those cycles.
- Flush and saturation: shift FWD 10 times → `fill_count`=4 (saturated), then FLUSH → all stages 0, `fill_count`=0, `primed`=0. FLUSH with `en`=0 → no effect.
- Async reset mid-run: assert `reset` between edges while shifting → outputs are 0 before the next edge. After release, the next FWD of 8'h5A reaches `data_out` after 4 edges.
- Default parameters (`WIDTH`=1, `DEPTH`=124): apply a random bitstream → `data_out` equals the input delayed by 124 enabled edges.
